id_ex_register: RTL and testbench
=================================

Name: id_ex_register

Overview:
- Pipeline register between the decode stage (control decoder, register file, immediate generator) and the execute stage of the 5-stage RISC-V core.
- Captures decoded control signals, operands, immediate, funct bits and register addresses each cycle.
- Supports stall (hold) and flush (bubble insertion).
- Exposes MemRead/RD address of the instruction in EX to the hazard detection unit for load-use detection.

Parameters:
- DATA_WIDTH, 32, width of operand, immediate and PC fields
- REG_ADDR_WIDTH, 5, register address width
- CNT_WIDTH, 32, width of the optional performance counters

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous active-high reset
- stall_i  in  1  hold all stored fields
- flush_i  in  1  load a bubble (control cleared, valid 0)
- valid_i  in  1  decode-stage instruction is valid
- ALUOp_i  in  2  ALU op class from decoder
- ALUSrc_i, RegWrite_i, MemToReg_i, MemRead_i, MemWrite_i, Branch_i  in  1 each  decoder control bits
- RS1data_i, RS2data_i  in  DATA_WIDTH  register file read data
- imm_i  in  DATA_WIDTH  sign-extended immediate
- pc_i  in  DATA_WIDTH  PC of decode instruction
- funct_i  in  10  {funct7, funct3}
- RS1addr_i, RS2addr_i, RDaddr_i  in  REG_ADDR_WIDTH  register indices
- all of the above data/control fields mirrored as *_o  out  same widths  registered copies
- valid_o  out  1  EX-stage instruction valid
- bubble_cnt_o  out  CNT_WIDTH  bubbles entered (optional feature)
- stall_cnt_o  out  CNT_WIDTH  stall cycles (optional feature)

Behaviour:
- Reset (asynchronous, on rst_i high, independent of clk_i): every output = 0, including valid_o and counters. Holds while rst_i is high; first capture is on the first rising edge after deassertion.
- Latency: 1 cycle; inputs sampled on rising clk_i, visible on *_o after the edge.
- Priority per edge: flush_i > stall_i > normal load.
- Normal (flush_i=0, stall_i=0):
  - All *_o <= *_i.
  - valid_o <= valid_i.
  - If valid_i=0, the control bits (RegWrite, MemRead, MemWrite, MemToReg, Branch, ALUSrc, ALUOp) are stored as 0 regardless of their inputs; data fields load normally.
- Stall (stall_i=1, flush_i=0): every output holds its value, including valid_o.
- Flush (flush_i=1): control bits and valid_o <= 0; RS1addr_o, RS2addr_o and RDaddr_o <= 0 so no forwarding match can occur; data, imm, pc and funct fields <= 0.
- Flush and stall in the same cycle: flush wins and the bubble is written.
- Invariant: valid_o=0 implies RegWrite_o=MemRead_o=MemWrite_o=Branch_o=0.
- No combinational path from any input to any output.
- Register x0: not special-cased; RDaddr_o=0 is passed through unchanged.

Optional Feature:
- Macro: IDEX_PERF_CNT_EN.
- Defined:
  - bubble_cnt_o increments by 1 on each edge where the register loads valid_o=0 (flush, or normal load with valid_i=0).
  - stall_cnt_o increments on each edge with stall_i=1 and flush_i=0.
  - Both wrap modulo 2^CNT_WIDTH and clear on reset.
- Not defined: both ports are driven constant 0 and no counter flops exist.

Test Plan:
- Reset: assert rst_i mid-cycle with valid_o=1, RegWrite_o=1, RS1data_o=0xDEADBEEF -> all outputs 0 immediately, before the next edge; stay 0 until the first edge after deassertion.
- Normal load: valid_i=1, RegWrite_i=1, ALUOp_i=2'b01, imm_i=0x00000010, RDaddr_i=5 -> next edge: valid_o=1, RegWrite_o=1, ALUOp_o=01, imm_o=0x10, RDaddr_o=5.
- Stall: after a load of RS2data_i=0x1234, hold stall_i=1 for 3 edges while inputs change to 0xFFFF -> RS2data_o stays 0x1234; with IDEX_PERF_CNT_EN, stall_cnt_o=3.
- Flush vs stall: stall_i=1 and flush_i=1 with MemWrite_i=1, RDaddr_i=7 -> next edge: valid_o=0, MemWrite_o=0, RDaddr_o=0; bubble_cnt_o increments by 1.
- Invalid input: valid_i=0, MemRead_i=1, RegWrite_i=1, RDaddr_i=3 -> valid_o=0, MemRead_o=0, RegWrite_o=0, RDaddr_o=3.
- Counter wrap (CNT_WIDTH=4, macro defined): 17 consecutive flush edges -> bubble_cnt_o=1.

Source files
------------

// File: rtl/id_ex_register.sv
// ID/EX pipeline register for the 5-stage RISC-V core.
// Captures decoded control, operands, immediate, PC, funct bits and register
// indices; supports stall (hold) and flush (bubble insertion).
// Optional macro IDEX_PERF_CNT_EN adds bubble and stall performance counters;
// when undefined, bubble_cnt_o and stall_cnt_o are tied to zero.
module id_ex_register #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      stall_i,
  input  logic                      flush_i,
  input  logic                      valid_i,
  input  logic [1:0]                ALUOp_i,
  input  logic                      ALUSrc_i,
  input  logic                      RegWrite_i,
  input  logic                      MemToReg_i,
  input  logic                      MemRead_i,
  input  logic                      MemWrite_i,
  input  logic                      Branch_i,
  input  logic [DATA_WIDTH-1:0]     RS1data_i,
  input  logic [DATA_WIDTH-1:0]     RS2data_i,
  input  logic [DATA_WIDTH-1:0]     imm_i,
  input  logic [DATA_WIDTH-1:0]     pc_i,
  input  logic [9:0]                funct_i,
  input  logic [REG_ADDR_WIDTH-1:0] RS1addr_i,
  input  logic [REG_ADDR_WIDTH-1:0] RS2addr_i,
  input  logic [REG_ADDR_WIDTH-1:0] RDaddr_i,
  output logic                      valid_o,
  output logic [1:0]                ALUOp_o,
  output logic                      ALUSrc_o,
  output logic                      RegWrite_o,
  output logic                      MemToReg_o,
  output logic                      MemRead_o,
  output logic                      MemWrite_o,
  output logic                      Branch_o,
  output logic [DATA_WIDTH-1:0]     RS1data_o,
  output logic [DATA_WIDTH-1:0]     RS2data_o,
  output logic [DATA_WIDTH-1:0]     imm_o,
  output logic [DATA_WIDTH-1:0]     pc_o,
  output logic [9:0]                funct_o,
  output logic [REG_ADDR_WIDTH-1:0] RS1addr_o,
  output logic [REG_ADDR_WIDTH-1:0] RS2addr_o,
  output logic [REG_ADDR_WIDTH-1:0] RDaddr_o,
  output logic [CNT_WIDTH-1:0]      bubble_cnt_o,
  output logic [CNT_WIDTH-1:0]      stall_cnt_o
);

  logic                      vld_p1;
  logic [1:0]                alu_op_p1;
  logic                      alu_src_p1;
  logic                      reg_write_p1;
  logic                      mem_to_reg_p1;
  logic                      mem_read_p1;
  logic                      mem_write_p1;
  logic                      branch_p1;
  logic [DATA_WIDTH-1:0]     rs1_data_p1;
  logic [DATA_WIDTH-1:0]     rs2_data_p1;
  logic [DATA_WIDTH-1:0]     imm_p1;
  logic [DATA_WIDTH-1:0]     pc_p1;
  logic [9:0]                funct_p1;
  logic [REG_ADDR_WIDTH-1:0] rs1_addr_p1;
  logic [REG_ADDR_WIDTH-1:0] rs2_addr_p1;
  logic [REG_ADDR_WIDTH-1:0] rd_addr_p1;

  // ID -> EX boundary: control bits and valid; an invalid instruction is
  // stored with cleared control so it can never write state in EX/MEM/WB.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i || flush_i) begin
      vld_p1        <= 1'b0;
      alu_op_p1     <= 2'b00;
      alu_src_p1    <= 1'b0;
      reg_write_p1  <= 1'b0;
      mem_to_reg_p1 <= 1'b0;
      mem_read_p1   <= 1'b0;
      mem_write_p1  <= 1'b0;
      branch_p1     <= 1'b0;
    end else if (!stall_i) begin
      vld_p1        <= valid_i;
      alu_op_p1     <= valid_i ? ALUOp_i : 2'b00;
      alu_src_p1    <= valid_i & ALUSrc_i;
      reg_write_p1  <= valid_i & RegWrite_i;
      mem_to_reg_p1 <= valid_i & MemToReg_i;
      mem_read_p1   <= valid_i & MemRead_i;
      mem_write_p1  <= valid_i & MemWrite_i;
      branch_p1     <= valid_i & Branch_i;
    end
  end

  // ID -> EX boundary: operands, immediate, PC, funct and register indices;
  // a flush zeroes the indices so a bubble never matches a forwarding source.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i || flush_i) begin
      rs1_data_p1 <= '0;
      rs2_data_p1 <= '0;
      imm_p1      <= '0;
      pc_p1       <= '0;
      funct_p1    <= '0;
      rs1_addr_p1 <= '0;
      rs2_addr_p1 <= '0;
      rd_addr_p1  <= '0;
    end else if (!stall_i) begin
      rs1_data_p1 <= RS1data_i;
      rs2_data_p1 <= RS2data_i;
      imm_p1      <= imm_i;
      pc_p1       <= pc_i;
      funct_p1    <= funct_i;
      rs1_addr_p1 <= RS1addr_i;
      rs2_addr_p1 <= RS2addr_i;
      rd_addr_p1  <= RDaddr_i;
    end
  end

  assign valid_o    = vld_p1;
  assign ALUOp_o    = alu_op_p1;
  assign ALUSrc_o   = alu_src_p1;
  assign RegWrite_o = reg_write_p1;
  assign MemToReg_o = mem_to_reg_p1;
  assign MemRead_o  = mem_read_p1;
  assign MemWrite_o = mem_write_p1;
  assign Branch_o   = branch_p1;
  assign RS1data_o  = rs1_data_p1;
  assign RS2data_o  = rs2_data_p1;
  assign imm_o      = imm_p1;
  assign pc_o       = pc_p1;
  assign funct_o    = funct_p1;
  assign RS1addr_o  = rs1_addr_p1;
  assign RS2addr_o  = rs2_addr_p1;
  assign RDaddr_o   = rd_addr_p1;

`ifdef IDEX_PERF_CNT_EN
  logic [CNT_WIDTH-1:0] bubble_cnt_p1;
  logic [CNT_WIDTH-1:0] stall_cnt_p1;

  // Count edges that load a bubble and edges that hold; both wrap freely.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bubble_cnt_p1 <= '0;
      stall_cnt_p1  <= '0;
    end else begin
      if (flush_i || (!stall_i && !valid_i))
        bubble_cnt_p1 <= bubble_cnt_p1 + CNT_WIDTH'(1);
      if (stall_i && !flush_i)
        stall_cnt_p1 <= stall_cnt_p1 + CNT_WIDTH'(1);
    end
  end

  assign bubble_cnt_o = bubble_cnt_p1;
  assign stall_cnt_o  = stall_cnt_p1;
`else
  assign bubble_cnt_o = '0;
  assign stall_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_id_ex_register.sv
// Scoreboard bench for id_ex_register: every driven cycle pushes the expected
// register contents; the value is popped and compared after the edge.
module tb_id_ex_register;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 4;

  typedef struct packed {
    logic          flush;
    logic          stall;
    logic          valid;
    logic [1:0]    aluop;
    logic          alusrc, regwrite, memtoreg, memread, memwrite, branch;
    logic [DW-1:0] rs1d, rs2d, imm, pc;
    logic [9:0]    funct;
    logic [AW-1:0] rs1a, rs2a, rda;
  } in_t;

  typedef struct packed {
    logic          valid;
    logic [1:0]    aluop;
    logic          alusrc, regwrite, memtoreg, memread, memwrite, branch;
    logic [DW-1:0] rs1d, rs2d, imm, pc;
    logic [9:0]    funct;
    logic [AW-1:0] rs1a, rs2a, rda;
    logic [CW-1:0] bubble, stall;
  } out_t;

  logic clk = 1'b0;
  logic rst_i = 1'b1;
  in_t  s = '0;
  out_t model = '0;
  out_t sb_q[$];
  int   n_checks = 0;
  int   n_pass = 0;

  logic          valid_o, ALUSrc_o, RegWrite_o, MemToReg_o, MemRead_o, MemWrite_o, Branch_o;
  logic [1:0]    ALUOp_o;
  logic [DW-1:0] RS1data_o, RS2data_o, imm_o, pc_o;
  logic [9:0]    funct_o;
  logic [AW-1:0] RS1addr_o, RS2addr_o, RDaddr_o;
  logic [CW-1:0] bubble_cnt_o, stall_cnt_o;

  always #5 clk = ~clk;

  id_ex_register #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk_i(clk), .rst_i(rst_i), .stall_i(s.stall), .flush_i(s.flush), .valid_i(s.valid),
    .ALUOp_i(s.aluop), .ALUSrc_i(s.alusrc), .RegWrite_i(s.regwrite), .MemToReg_i(s.memtoreg),
    .MemRead_i(s.memread), .MemWrite_i(s.memwrite), .Branch_i(s.branch),
    .RS1data_i(s.rs1d), .RS2data_i(s.rs2d), .imm_i(s.imm), .pc_i(s.pc), .funct_i(s.funct),
    .RS1addr_i(s.rs1a), .RS2addr_i(s.rs2a), .RDaddr_i(s.rda),
    .valid_o(valid_o), .ALUOp_o(ALUOp_o), .ALUSrc_o(ALUSrc_o), .RegWrite_o(RegWrite_o),
    .MemToReg_o(MemToReg_o), .MemRead_o(MemRead_o), .MemWrite_o(MemWrite_o), .Branch_o(Branch_o),
    .RS1data_o(RS1data_o), .RS2data_o(RS2data_o), .imm_o(imm_o), .pc_o(pc_o), .funct_o(funct_o),
    .RS1addr_o(RS1addr_o), .RS2addr_o(RS2addr_o), .RDaddr_o(RDaddr_o),
    .bubble_cnt_o(bubble_cnt_o), .stall_cnt_o(stall_cnt_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  // Reference behaviour of one clock edge (reset handled by the caller).
  function automatic out_t next_state(out_t c, in_t i);
    out_t n = c;
    if (i.flush) begin
      n = '0;
      n.stall = c.stall;
`ifdef IDEX_PERF_CNT_EN
      n.bubble = c.bubble + 1'b1;
`endif
    end else if (i.stall) begin
`ifdef IDEX_PERF_CNT_EN
      n.stall = c.stall + 1'b1;
`endif
    end else begin
      n.valid    = i.valid;
      n.aluop    = i.valid ? i.aluop : 2'b00;
      n.alusrc   = i.valid & i.alusrc;
      n.regwrite = i.valid & i.regwrite;
      n.memtoreg = i.valid & i.memtoreg;
      n.memread  = i.valid & i.memread;
      n.memwrite = i.valid & i.memwrite;
      n.branch   = i.valid & i.branch;
      n.rs1d = i.rs1d; n.rs2d = i.rs2d; n.imm = i.imm; n.pc = i.pc;
      n.funct = i.funct; n.rs1a = i.rs1a; n.rs2a = i.rs2a; n.rda = i.rda;
`ifdef IDEX_PERF_CNT_EN
      if (!i.valid) n.bubble = c.bubble + 1'b1;
`endif
    end
    return n;
  endfunction

  task automatic compare_out(input string ctx);
    out_t e;
    if (sb_q.size() == 0) begin
      check({ctx, ".sb_empty"}, 64'd0, 64'd1);
      return;
    end
    e = sb_q.pop_front();
    check({ctx, ".valid"}, valid_o, e.valid);
    check({ctx, ".ctrl"}, {ALUOp_o, ALUSrc_o, RegWrite_o, MemToReg_o, MemRead_o, MemWrite_o, Branch_o},
          {e.aluop, e.alusrc, e.regwrite, e.memtoreg, e.memread, e.memwrite, e.branch});
    check({ctx, ".rs1d"}, RS1data_o, e.rs1d);
    check({ctx, ".rs2d"}, RS2data_o, e.rs2d);
    check({ctx, ".imm"}, imm_o, e.imm);
    check({ctx, ".pc"}, pc_o, e.pc);
    check({ctx, ".funct"}, funct_o, e.funct);
    check({ctx, ".addr"}, {RS1addr_o, RS2addr_o, RDaddr_o}, {e.rs1a, e.rs2a, e.rda});
    check({ctx, ".bubble"}, bubble_cnt_o, e.bubble);
    check({ctx, ".stallcnt"}, stall_cnt_o, e.stall);
    if (valid_o === 1'b0)
      check({ctx, ".inv"}, {RegWrite_o, MemRead_o, MemWrite_o, Branch_o}, 4'b0000);
  endtask

  task automatic step(input string ctx, input in_t i);
    @(negedge clk);
    s = i;
    model = next_state(model, i);
    sb_q.push_back(model);
    @(posedge clk);
    #1;
    compare_out(ctx);
  endtask

  task automatic reset_now(input string ctx);
    @(negedge clk);
    rst_i = 1'b1;
    model = '0;
    sb_q.push_back(model);
    #1;
    compare_out({ctx, ".async"});
    sb_q.push_back(model);
    @(posedge clk);
    #1;
    compare_out({ctx, ".held"});
    @(negedge clk);
    rst_i = 1'b0;
  endtask

  function automatic in_t rand_in();
    in_t r;
    r.flush = ($urandom_range(0, 7) == 0);
    r.stall = ($urandom_range(0, 4) == 0);
    r.valid = ($urandom_range(0, 3) != 0);
    r.aluop = 2'($urandom);
    {r.alusrc, r.regwrite, r.memtoreg, r.memread, r.memwrite, r.branch} = 6'($urandom);
    r.rs1d = $urandom; r.rs2d = $urandom; r.imm = $urandom; r.pc = $urandom;
    r.funct = 10'($urandom);
    r.rs1a = 5'($urandom); r.rs2a = 5'($urandom); r.rda = 5'($urandom);
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    in_t t;
    // Reset held from time 0, with live inputs applied during an edge.
    s = '0;
    s.valid = 1'b1; s.regwrite = 1'b1; s.rs1d = 32'hDEADBEEF; s.rda = 5'd9;
    sb_q.push_back('0);
    #2;
    compare_out("rst_init");
    sb_q.push_back('0);
    @(posedge clk);
    #1;
    compare_out("rst_edge");
    @(negedge clk);
    rst_i = 1'b0;

    // Normal load
    t = '0;
    t.valid = 1'b1; t.regwrite = 1'b1; t.aluop = 2'b01; t.imm = 32'h10; t.rda = 5'd5;
    t.rs1d = 32'hDEADBEEF; t.pc = 32'h100; t.funct = 10'h2A5; t.rs1a = 5'd1; t.rs2a = 5'd2;
    step("load", t);

    // Mid-cycle reset with live state
    reset_now("rst_mid");

    // Stall holds for three edges
    t = '0;
    t.valid = 1'b1; t.rs2d = 32'h1234; t.memread = 1'b1; t.rda = 5'd4;
    step("stall_ld", t);
    t.rs2d = 32'hFFFF; t.stall = 1'b1; t.rda = 5'd11;
    for (int k = 0; k < 3; k++) step("stall", t);
    check("stall_rs2d", RS2data_o, 32'h1234);
`ifdef IDEX_PERF_CNT_EN
    check("stall_cnt3", stall_cnt_o, 4'd3);
`endif

    // Flush wins over stall
    t = '0;
    t.valid = 1'b1; t.stall = 1'b1; t.flush = 1'b1; t.memwrite = 1'b1; t.rda = 5'd7;
    t.rs1d = 32'h55; t.imm = 32'h77;
    step("flush_stall", t);

    // Invalid decode instruction
    t = '0;
    t.valid = 1'b0; t.memread = 1'b1; t.regwrite = 1'b1; t.rda = 5'd3; t.aluop = 2'b10;
    t.rs1d = 32'hA5A5A5A5;
    step("invalid", t);

    // x0 destination passes through
    t = '0;
    t.valid = 1'b1; t.regwrite = 1'b1; t.rda = 5'd0; t.rs1a = 5'd31; t.branch = 1'b1;
    step("rd_x0", t);

    // Mixed random traffic
    for (int k = 0; k < 40; k++) step("rand", rand_in());

    // Counter wrap: 17 flushes from reset
    reset_now("rst_wrap");
    t = '0;
    t.flush = 1'b1; t.valid = 1'b1;
    for (int k = 0; k < 17; k++) step("wrap", t);
`ifdef IDEX_PERF_CNT_EN
    check("wrap_bubble", bubble_cnt_o, 4'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
